// File: rtl/pa_soc_uart_rx_pkg.sv
// pa_soc_uart_rx_pkg: register offsets, RX state encoding and SR bit positions shared by the UART blocks.
package pa_soc_uart_rx_pkg;

    localparam logic [7:0] UART_REG_CR  = 8'h00;
    localparam logic [7:0] UART_REG_SR  = 8'h04;
    localparam logic [7:0] UART_REG_RXD = 8'h10;

    localparam int SR_RX_VALID  = 0;
    localparam int SR_OVERRUN   = 1;
    localparam int SR_FRAME_ERR = 2;
    localparam int SR_FULL      = 3;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    function automatic logic [31:0] sr_word(input logic full, input logic ferr,
                                            input logic ovr, input logic valid);
        return {28'b0, full, ferr, ovr, valid};
    endfunction

endpackage

// File: rtl/pa_soc_uart_rx_fifo.sv
// pa_soc_uart_rx_fifo: 4x8 receive FIFO with read/write pointers and an occupancy count.
module pa_soc_uart_rx_fifo (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       empty_o,
    output logic       full_o
);

    logic [7:0] mem_q [4];
    logic [1:0] wr_q, rd_q;
    logic [2:0] count_q;

    assign data_o  = mem_q[rd_q];
    assign empty_o = count_q == 3'd0;
    assign full_o  = count_q == 3'd4;

    // Caller gates push against full, so a push while full only happens alongside a pop.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= 8'h00;
            wr_q    <= 2'd0;
            rd_q    <= 2'd0;
            count_q <= 3'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + 2'd1;
            end
            if (pop_i) rd_q <= rd_q + 2'd1;
            count_q <= count_q + {2'b0, push_i} - {2'b0, pop_i};
        end
    end

endmodule

// File: rtl/pa_soc_uart_rx.sv
// pa_soc_uart_rx: 8N1 UART receiver with CR/SR/RXD register interface.
// Define PA_SOC_UART_RX_FIFO_EN to replace the holding register with a 4-entry FIFO.
module pa_soc_uart_rx
    import pa_soc_uart_rx_pkg::*;
#(
    parameter int CPU_FREQ_HZ = 50_000_000,
    parameter int UART_BAUD   = 115200,
    parameter int CLK_DIV     = CPU_FREQ_HZ / UART_BAUD
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [7:0]  addr_i,
    input  logic        data_rd_i,
    input  logic        data_we_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic        pad_rxd
);

    localparam logic [15:0] CNT_HALF = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0] CNT_FULL = 16'(CLK_DIV - 1);

    logic        sync1_q, sync2_q, prev_q;
    rx_state_e   state_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        commit_q, ferr_set_q;
    logic [31:0] cr_q;
    logic        ovr_q, ferr_q;
    logic        rx_en, fall, tick, rd_rxd, we_sr, ovr_set;
    logic        rx_valid, rx_full;
    logic [7:0]  rxd_byte;

    assign rx_en  = cr_q[0];
    assign fall   = prev_q & ~sync2_q;
    assign tick   = cnt_q == 16'd0;
    assign rd_rxd = data_rd_i & (addr_i == UART_REG_RXD);
    assign we_sr  = data_we_i & (addr_i == UART_REG_SR);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= pad_rxd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= RX_IDLE;
            cnt_q      <= 16'd0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            commit_q   <= 1'b0;
            ferr_set_q <= 1'b0;
        end else begin
            commit_q   <= 1'b0;
            ferr_set_q <= 1'b0;
            if (!rx_en) begin
                state_q <= RX_IDLE;
            end else begin
                case (state_q)
                    RX_IDLE: if (fall) begin
                        state_q <= RX_START;
                        cnt_q   <= CNT_HALF;
                    end
                    RX_START: if (tick) begin
                        state_q <= sync2_q ? RX_IDLE : RX_DATA;
                        bit_q   <= 3'd0;
                        cnt_q   <= CNT_FULL;
                    end else cnt_q <= cnt_q - 16'd1;
                    RX_DATA: if (tick) begin
                        shift_q <= {sync2_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        cnt_q   <= CNT_FULL;
                        if (bit_q == 3'd7) state_q <= RX_STOP;
                    end else cnt_q <= cnt_q - 16'd1;
                    RX_STOP: if (tick) begin
                        commit_q   <= sync2_q;
                        ferr_set_q <= ~sync2_q;
                        state_q    <= RX_IDLE;
                    end else cnt_q <= cnt_q - 16'd1;
                    default: state_q <= RX_IDLE;
                endcase
            end
        end
    end

`ifdef PA_SOC_UART_RX_FIFO_EN
    logic f_empty, f_full, f_pop;

    assign f_pop    = rd_rxd & ~f_empty;
    assign rx_valid = ~f_empty;
    assign rx_full  = f_full;
    assign ovr_set  = commit_q & f_full & ~f_pop;

    pa_soc_uart_rx_fifo u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (commit_q & (~f_full | f_pop)),
        .pop_i   (f_pop),
        .data_i  (shift_q),
        .data_o  (rxd_byte),
        .empty_o (f_empty),
        .full_o  (f_full)
    );
`else
    logic [7:0] rxd_q;
    logic       valid_q;

    assign rx_valid = valid_q;
    assign rx_full  = 1'b0;
    assign rxd_byte = rxd_q;
    // A read in the commit cycle consumes the old byte, so it is not an overrun.
    assign ovr_set  = commit_q & valid_q & ~rd_rxd;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rxd_q   <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            if (commit_q) rxd_q <= shift_q;
            valid_q <= commit_q | (valid_q & ~rd_rxd & ~(we_sr & data_i[SR_RX_VALID]));
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cr_q   <= 32'h1;
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            if (data_we_i && addr_i == UART_REG_CR) cr_q <= data_i;
            ovr_q  <= ovr_set | (ovr_q & ~(we_sr & data_i[SR_OVERRUN]));
            ferr_q <= ferr_set_q | (ferr_q & ~(we_sr & data_i[SR_FRAME_ERR]));
        end
    end

    assign data_o = !data_rd_i                ? 32'h0 :
                    addr_i == UART_REG_CR     ? cr_q :
                    addr_i == UART_REG_SR     ? sr_word(rx_full, ferr_q, ovr_q, rx_valid) :
                    addr_i == UART_REG_RXD    ? {24'h0, rxd_byte} : 32'h0;

endmodule

// File: tb/tb_pa_soc_uart_rx.sv
// tb_pa_soc_uart_rx: randomized frame/bus traffic against a queue-based register model.
module tb_pa_soc_uart_rx;

    localparam int DIV = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  addr = 8'h00;
    logic        rd = 1'b0;
    logic        we = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        pad = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    logic       m_valid, m_ovr, m_ferr;
    logic [7:0] m_rxd;
    logic [7:0] m_q[$];

    always #5 clk = ~clk;

    pa_soc_uart_rx #(.CPU_FREQ_HZ(1_152_000), .UART_BAUD(115200)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .addr_i    (addr),
        .data_rd_i (rd),
        .data_we_i (we),
        .data_i    (wdata),
        .data_o    (rdata),
        .pad_rxd   (pad)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_sr();
`ifdef PA_SOC_UART_RX_FIFO_EN
        return {28'b0, m_q.size() == 4, m_ferr, m_ovr, m_q.size() != 0};
`else
        return {28'b0, 1'b0, m_ferr, m_ovr, m_valid};
`endif
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
        m_rxd   = 8'h00;
        m_q.delete();
    endtask

    task automatic model_frame(input logic [7:0] b, input bit stop);
        if (!stop) m_ferr = 1'b1;
`ifdef PA_SOC_UART_RX_FIFO_EN
        else if (m_q.size() == 4) m_ovr = 1'b1;
        else m_q.push_back(b);
`else
        else begin
            if (m_valid) m_ovr = 1'b1;
            m_rxd   = b;
            m_valid = 1'b1;
        end
`endif
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a;
        rd   = 1'b1;
        #1 d = rdata;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop);
        @(negedge clk);
        pad = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            pad = b[i];
            repeat (DIV) @(negedge clk);
        end
        pad = stop;
        repeat (DIV) @(negedge clk);
        pad = 1'b1;
        repeat (2 * DIV) @(negedge clk);
    endtask

    task automatic rx_frame(input logic [7:0] b, input bit stop);
        send_frame(b, stop);
        model_frame(b, stop);
    endtask

    task automatic read_sr(input string tag);
        logic [31:0] d;
        bus_read(8'h04, d);
        check(tag, d, exp_sr());
    endtask

    task automatic read_rxd(input string tag);
        logic [31:0] d;
`ifdef PA_SOC_UART_RX_FIFO_EN
        if (m_q.size() != 0) begin
            bus_read(8'h10, d);
            check(tag, d, {24'h0, m_q.pop_front()});
        end
`else
        bus_read(8'h10, d);
        check(tag, d, {24'h0, m_rxd});
        m_valid = 1'b0;
`endif
    endtask

    task automatic write_sr(input logic [3:0] w);
        bus_write(8'h04, {28'h0, w});
        if (w[1]) m_ovr = 1'b0;
        if (w[2]) m_ferr = 1'b0;
`ifndef PA_SOC_UART_RX_FIFO_EN
        if (w[0]) m_valid = 1'b0;
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        bus_read(8'h00, d);
        check("reset_cr", d, 32'h1);
        read_sr("reset_sr");
        bus_read(8'h10, d);
        check("reset_rxd", d, 32'h0);
        bus_read(8'h08, d);
        check("unmapped", d, 32'h0);
        @(negedge clk);
        addr = 8'h00;
        #1 check("no_rd_zero", rdata, 32'h0);

        rx_frame(8'h55, 1'b1);
        read_sr("sr_after_55");
        read_rxd("rxd_55");
        read_sr("sr_after_read");

        rx_frame(8'hA3, 1'b1);
        rx_frame(8'h3C, 1'b1);
        read_sr("sr_two_frames");
        read_rxd("rxd_two_frames");
        write_sr(4'h2);
        read_sr("sr_w1c_ovr");

        rx_frame($urandom_range(0, 255), 1'b0);
        read_sr("sr_frame_err");
        read_rxd("rxd_after_ferr");
        write_sr(4'h4);
        read_sr("sr_ferr_clr");

        @(negedge clk);
        pad = 1'b0;
        repeat (3) @(negedge clk);
        pad = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        read_sr("sr_glitch");

        fork
            send_frame(8'hC6, 1'b1);
            begin
                repeat (5 * DIV + 5) @(negedge clk);
                bus_write(8'h00, 32'h0);
            end
        join
        bus_write(8'h00, 32'h1);
        bus_read(8'h00, d);
        check("cr_restored", d, 32'h1);
        read_sr("sr_rx_en_abort");
        rx_frame(8'h81, 1'b1);
        read_sr("sr_81");
        read_rxd("rxd_81");

        rx_frame(8'h9E, 1'b1);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (4 * DIV) @(negedge clk);
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        model_reset();
        read_sr("sr_reset_midframe");
        bus_read(8'h10, d);
        check("rxd_reset_midframe", d, 32'h0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: rx_frame(8'($urandom_range(0, 255)), 1'b1);
                3:       rx_frame(8'($urandom_range(0, 255)), 1'b0);
                4:       read_rxd($sformatf("rand_rxd_%0d", i));
                default: write_sr(4'($urandom_range(0, 15)));
            endcase
            read_sr($sformatf("rand_sr_%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
